// File: rtl/picorv32_trace_capture_pkg.sv
// Shared definitions for the PicoRV32 trace capture block.
//   TRACE_W     : trace word width produced by picorv32_demo_system
//   trc_state_e : capture FSM encoding, also exported on state_o
package picorv32_trace_capture_pkg;

    localparam int TRACE_W = 36;

    typedef enum logic [1:0] {
        TRC_IDLE  = 2'd0,
        TRC_ARMED = 2'd1,
        TRC_POST  = 2'd2,
        TRC_DONE  = 2'd3
    } trc_state_e;

endpackage

// File: rtl/picorv32_trace_capture_ram.sv
// Simple dual-port RAM for the trace history buffer.
// One write port and one synchronous read port (1-cycle latency).
// The read register holds its value while rd_en_i is low. No reset, so the
// array maps onto block RAM.
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read strobe, data appears on rd_data_o next cycle
//   rd_addr_i  : read address
//   rd_data_o  : registered read data
module trace_capture_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 36
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_r;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_r[wr_addr_i] <= wr_data_i;
        end
    end

    // Synchronous read port; output register keeps the last word read.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_r <= mem_r[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_r;

endmodule

// File: rtl/picorv32_trace_capture.sv
// PicoRV32 instruction-trace capture.
// Records trace words into a circular history buffer once armed, freezes the
// buffer POST_TRIG words after the first trap rising edge, then replays the
// frozen window oldest-first on a valid/ready stream.
//   clk_i / rst_i          : clock, synchronous active-high reset
//   trace_valid_i/_data_i  : trace stream from the core
//   trap_i                 : trap flag, rising edge is the trigger
//   arm_i                  : one-cycle pulse, clears the buffer and (re)starts capture
//   rd_data_o/rd_valid_o   : replay stream out, handshaked with rd_ready_i
//   state_o                : 0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   count_o                : number of words in the frozen window
module picorv32_trace_capture
    import picorv32_trace_capture_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int DATA_W     = TRACE_W,
    parameter int POST_TRIG  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  trace_valid_i,
    input  logic [DATA_W-1:0]     trace_data_i,
    input  logic                  trap_i,
    input  logic                  arm_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [1:0]            state_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int A = DEPTH_LOG2;

    localparam logic [A:0]   CNT_ZERO_C  = {(A+1){1'b0}};
    localparam logic [A:0]   CNT_ONE_C   = {{A{1'b0}}, 1'b1};
    localparam logic [A:0]   DEPTH_C     = {1'b1, {A{1'b0}}};
    localparam logic [A-1:0] PTR_ZERO_C  = {A{1'b0}};
    localparam logic [A-1:0] PTR_ONE_C   = {{(A-1){1'b0}}, 1'b1};
    localparam logic [A:0]   POST_TRIG_C = (A+1)'(POST_TRIG);
    localparam logic         NO_POST_C   = (POST_TRIG == 32'sd0);

    trc_state_e        state_r;
    logic [A-1:0]      wr_ptr_r;
    logic [A:0]        fill_r;
    logic [A:0]        post_cnt_r;
    logic [A:0]        issued_cnt_r;   // replay reads issued to the RAM
    logic [A:0]        popped_cnt_r;   // replay words accepted by the consumer
    logic              trap_q_r;
    logic              rd_pend_r;      // RAM read register holds an unconsumed word
    logic              rd_valid_r;
    logic [DATA_W-1:0] rd_data_r;

    logic              trig_s;
    logic              wr_en_s;
    logic              replay_s;
    logic              pop_s;
    logic              load_s;
    logic              rd_en_s;
    logic              last_pop_s;
    logic [A-1:0]      rd_addr_s;
    logic [A:0]        post_cnt_inc_s;
    logic [DATA_W-1:0] ram_q_s;

    // Datapath control: trigger detect, RAM write/read strobes, replay handshake.
    always_comb begin
        trig_s         = trap_i & ~trap_q_r;
        post_cnt_inc_s = post_cnt_r + CNT_ONE_C;

        if ((state_r == TRC_ARMED) || (state_r == TRC_POST)) begin
            wr_en_s = trace_valid_i & ~arm_i;
        end else begin
            wr_en_s = 1'b0;
        end

        replay_s = (state_r == TRC_DONE) & ~arm_i;
        pop_s    = replay_s & rd_valid_r & rd_ready_i;
        // Refill the output register when it is empty or being emptied.
        load_s   = replay_s & rd_pend_r & (~rd_valid_r | pop_s);
        // Only overwrite the RAM read register once its word has moved on.
        rd_en_s  = replay_s & (issued_cnt_r < fill_r) & (~rd_pend_r | load_s);
        // Oldest word sits fill entries behind the write pointer, mod depth.
        rd_addr_s  = wr_ptr_r - fill_r[A-1:0] + issued_cnt_r[A-1:0];
        last_pop_s = pop_s & (popped_cnt_r == (fill_r - CNT_ONE_C));
    end

    // Capture/replay FSM with pointers, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= TRC_IDLE;
            wr_ptr_r     <= PTR_ZERO_C;
            fill_r       <= CNT_ZERO_C;
            post_cnt_r   <= CNT_ZERO_C;
            issued_cnt_r <= CNT_ZERO_C;
            popped_cnt_r <= CNT_ZERO_C;
            trap_q_r     <= 1'b0;
            rd_pend_r    <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_data_r    <= {DATA_W{1'b0}};
        end else begin
            trap_q_r <= trap_i;
            if (arm_i) begin
                // Arm from any state restarts capture and drops any replay.
                state_r      <= TRC_ARMED;
                wr_ptr_r     <= PTR_ZERO_C;
                fill_r       <= CNT_ZERO_C;
                post_cnt_r   <= CNT_ZERO_C;
                issued_cnt_r <= CNT_ZERO_C;
                popped_cnt_r <= CNT_ZERO_C;
                rd_pend_r    <= 1'b0;
                rd_valid_r   <= 1'b0;
            end else begin
                case (state_r)
                    TRC_IDLE: begin
                        state_r <= TRC_IDLE;
                    end
                    TRC_ARMED: begin
                        if (wr_en_s) begin
                            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
                            if (fill_r != DEPTH_C) begin
                                fill_r <= fill_r + CNT_ONE_C;
                            end
                        end
                        // A word written with the trigger is a pre-trigger word.
                        if (trig_s) begin
                            post_cnt_r <= CNT_ZERO_C;
                            if (NO_POST_C) begin
                                state_r <= TRC_DONE;
                            end else begin
                                state_r <= TRC_POST;
                            end
                        end
                    end
                    TRC_POST: begin
                        if (wr_en_s) begin
                            wr_ptr_r   <= wr_ptr_r + PTR_ONE_C;
                            post_cnt_r <= post_cnt_inc_s;
                            if (fill_r != DEPTH_C) begin
                                fill_r <= fill_r + CNT_ONE_C;
                            end
                            if (post_cnt_inc_s == POST_TRIG_C) begin
                                state_r <= TRC_DONE;
                            end
                        end
                    end
                    TRC_DONE: begin
                        if (rd_en_s) begin
                            issued_cnt_r <= issued_cnt_r + CNT_ONE_C;
                            rd_pend_r    <= 1'b1;
                        end else if (load_s) begin
                            rd_pend_r <= 1'b0;
                        end
                        if (load_s) begin
                            rd_data_r  <= ram_q_s;
                            rd_valid_r <= 1'b1;
                        end else if (pop_s) begin
                            rd_valid_r <= 1'b0;
                        end
                        if (pop_s) begin
                            popped_cnt_r <= popped_cnt_r + CNT_ONE_C;
                        end
                        // Empty window or last word accepted: replay finished.
                        if ((fill_r == CNT_ZERO_C) || last_pop_s) begin
                            state_r      <= TRC_IDLE;
                            rd_valid_r   <= 1'b0;
                            rd_pend_r    <= 1'b0;
                            issued_cnt_r <= CNT_ZERO_C;
                            popped_cnt_r <= CNT_ZERO_C;
                        end
                    end
                    default: begin
                        state_r <= TRC_IDLE;
                    end
                endcase
            end
        end
    end

    trace_capture_ram #(
        .ADDR_W (A),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (wr_ptr_r),
        .wr_data_i (trace_data_i),
        .rd_en_i   (rd_en_s),
        .rd_addr_i (rd_addr_s),
        .rd_data_o (ram_q_s)
    );

    assign rd_data_o  = rd_data_r;
    assign rd_valid_o = rd_valid_r;
    assign state_o    = state_r;
    assign count_o    = fill_r;

endmodule

// File: tb/tb_picorv32_trace_capture.sv
// Self-checking bench for picorv32_trace_capture (DEPTH_LOG2=4).
// u_dut uses POST_TRIG=4, u_dut0 uses POST_TRIG=0; both share the inputs.
// Reference model: a queue of every word pushed since the last arm; the
// expected replay is simply its last min(16, size) entries in push order.
module tb_picorv32_trace_capture;

    localparam int DEPTH = 16;
    localparam int TMO   = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trace_valid = 1'b0;
    logic [35:0] trace_data = 36'd0;
    logic        trap = 1'b0;
    logic        arm = 1'b0;
    logic        rd_ready = 1'b0;

    logic [35:0] rd_data;
    logic        rd_valid;
    logic [1:0]  state;
    logic [4:0]  count;
    logic [35:0] d0_rd_data;
    logic        d0_rd_valid;
    logic [1:0]  d0_state;
    logic [4:0]  d0_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [35:0] hist[$];

    always #5 clk = ~clk;

    picorv32_trace_capture #(.DEPTH_LOG2(4), .DATA_W(36), .POST_TRIG(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .trace_valid_i(trace_valid), .trace_data_i(trace_data),
        .trap_i(trap), .arm_i(arm), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .rd_ready_i(rd_ready), .state_o(state), .count_o(count)
    );

    picorv32_trace_capture #(.DEPTH_LOG2(4), .DATA_W(36), .POST_TRIG(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .trace_valid_i(trace_valid), .trace_data_i(trace_data),
        .trap_i(trap), .arm_i(arm), .rd_data_o(d0_rd_data), .rd_valid_o(d0_rd_valid),
        .rd_ready_i(rd_ready), .state_o(d0_state), .count_o(d0_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
        hist.delete();
    endtask

    task automatic push(input logic [35:0] w);
        trace_valid = 1'b1;
        trace_data  = w;
        hist.push_back(w);
        step();
        trace_valid = 1'b0;
    endtask

    task automatic push_trap(input logic [35:0] w);
        trap = 1'b1;
        push(w);
        trap = 1'b0;
    endtask

    task automatic trap_pulse();
        trap = 1'b1;
        step();
        trap = 1'b0;
    endtask

    function automatic logic [35:0] rand_word();
        return {4'($urandom_range(0, 15)), 32'($urandom)};
    endfunction

    // mode 0: ready high, 1: ready toggling, 2: ready random
    task automatic drain(input int mode);
        logic [35:0] exp_q[$];
        logic [35:0] hold_d;
        logic        hold;
        int idx;
        int k;
        int first_k;
        int st;
        idx = 0; k = 0; first_k = -1; hold = 1'b0; hold_d = 36'd0;
        st = (hist.size() > DEPTH) ? hist.size() - DEPTH : 0;
        for (int i = st; i < hist.size(); i++) exp_q.push_back(hist[i]);
        check("done_state", 64'(state), 64'd3);
        check("count", 64'(count), 64'(exp_q.size()));
        while (state !== 2'd0 && k < TMO) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (k % 2 == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (hold) begin
                check("hold_valid", 64'(rd_valid), 64'd1);
                check("hold_data", 64'(rd_data), 64'(hold_d));
            end
            if (rd_valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                if (rd_ready) begin
                    if (idx < exp_q.size()) check("replay_data", 64'(rd_data), 64'(exp_q[idx]));
                    else check("extra_word", 64'(idx), 64'(exp_q.size()));
                    idx++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    hold_d = rd_data;
                end
            end
            step();
            k++;
        end
        rd_ready = 1'b0;
        check("drain_in_time", 64'(k < TMO), 64'd1);
        check("replay_count", 64'(idx), 64'(exp_q.size()));
        check("end_valid", 64'(rd_valid), 64'd0);
        if (mode == 0 && exp_q.size() > 0) begin
            check("first_valid_lat", 64'(first_k), 64'd2);
            check("end_cycle", 64'(k), 64'(exp_q.size() + 2));
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_state", 64'(state), 64'd0);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_state0", 64'(d0_state), 64'd0);

        // 1: basic capture and in-order replay
        arm_pulse();
        check("armed", 64'(state), 64'd1);
        for (int i = 0; i < 10; i++) push(36'(i));
        trap_pulse();
        check("post", 64'(state), 64'd2);
        for (int i = 10; i < 13; i++) push(36'(i));
        check("still_post", 64'(state), 64'd2);
        push(36'd13);
        drain(0);
        check("idle_after", 64'(state), 64'd0);

        // 2: wrap-around window
        arm_pulse();
        for (int i = 0; i < 40; i++) push(36'(i));
        trap_pulse();
        for (int i = 40; i < 44; i++) push(36'(i));
        drain(0);

        // 3: toggling ready
        arm_pulse();
        for (int i = 0; i < 10; i++) push(36'(i));
        trap_pulse();
        for (int i = 10; i < 14; i++) push(36'(i));
        drain(1);

        // 4: trap high across arm is not a trigger; same-cycle word is pre-trigger
        trap = 1'b1;
        step();
        arm_pulse();
        for (int i = 0; i < 5; i++) push(rand_word());
        check("trap_held_armed", 64'(state), 64'd1);
        trap = 1'b0;
        step();
        check("trap_low_armed", 64'(state), 64'd1);
        push_trap(rand_word());
        check("trig_post", 64'(state), 64'd2);
        for (int i = 0; i < 3; i++) push(rand_word());
        check("post3", 64'(state), 64'd2);
        push(rand_word());
        drain(2);

        // 5: POST_TRIG=0, trigger with empty buffer
        do_reset();
        arm_pulse();
        trap_pulse();
        check("p0_done", 64'(d0_state), 64'd3);
        check("p0_count", 64'(d0_count), 64'd0);
        check("p0_valid_a", 64'(d0_rd_valid), 64'd0);
        rd_ready = 1'b1;
        step();
        check("p0_idle", 64'(d0_state), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("p0_valid_b", 64'(d0_rd_valid), 64'd0);
            step();
        end
        rd_ready = 1'b0;

        // 6: reset mid-POST and mid-replay, then re-arm
        arm_pulse();
        for (int i = 0; i < 3; i++) push(rand_word());
        trap_pulse();
        push(rand_word());
        push(rand_word());
        check("mid_post", 64'(state), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_post_state", 64'(state), 64'd0);
        check("rst_post_valid", 64'(rd_valid), 64'd0);
        check("rst_post_count", 64'(count), 64'd0);
        arm_pulse();
        for (int i = 0; i < 10; i++) push(rand_word());
        trap_pulse();
        for (int i = 0; i < 4; i++) push(rand_word());
        check("mid_done", 64'(state), 64'd3);
        rd_ready = 1'b1;
        step(); step(); step();
        check("replay_running", 64'(rd_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_ready = 1'b0;
        check("rst_rep_state", 64'(state), 64'd0);
        check("rst_rep_valid", 64'(rd_valid), 64'd0);
        check("rst_rep_count", 64'(count), 64'd0);
        arm_pulse();
        for (int i = 0; i < 10; i++) push(rand_word());
        trap_pulse();
        for (int i = 0; i < 4; i++) push(rand_word());
        drain(0);

        // Abort: arm during replay restarts capture
        arm_pulse();
        for (int i = 0; i < 6; i++) push(rand_word());
        trap_pulse();
        for (int i = 0; i < 4; i++) push(rand_word());
        rd_ready = 1'b1;
        step(); step(); step();
        arm = 1'b1;
        step();
        arm = 1'b0;
        rd_ready = 1'b0;
        hist.delete();
        check("abort_state", 64'(state), 64'd1);
        check("abort_valid", 64'(rd_valid), 64'd0);
        check("abort_count", 64'(count), 64'd0);
        for (int i = 0; i < 7; i++) push(rand_word());
        trap_pulse();
        for (int i = 0; i < 4; i++) push(rand_word());
        drain(0);

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            int n_pre;
            arm_pulse();
            n_pre = $urandom_range(0, 30);
            for (int i = 0; i < n_pre; i++) begin
                if ($urandom_range(0, 3) == 0) step();
                push(rand_word());
            end
            if (n_pre > 0 && $urandom_range(0, 1) == 1) push_trap(rand_word());
            else trap_pulse();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0) step();
                push(rand_word());
            end
            drain(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
